// File: rtl/router_pkg.sv
// Shared router constants and types: buffer count, address/priority widths, destination count.
package router_pkg;

    localparam int unsigned NUM_BUF    = 7;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned PRI_W      = 3;
    localparam int unsigned NUM_DEST   = 2 ** ADDR_W;
    localparam int unsigned LOCAL_ADDR = 0;

    typedef logic [PRI_W-1:0]  pri_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/dest_picker.sv
// Combinational oldest-first picker for one destination: one-hot grant of the occupied
// buffer addressed to Dest with the smallest nonzero priority, gated by ready.
module dest_picker
    import router_pkg::*;
#(
    parameter int unsigned Dest = 0
) (
    input  logic [NUM_BUF*PRI_W-1:0]  pri,
    input  logic [NUM_BUF*ADDR_W-1:0] dest,
    input  logic                      ready,
    output logic [NUM_BUF-1:0]        grant
);

    logic found;
    pri_t best;

    always_comb begin
        grant = '0;
        found = 1'b0;
        best  = '0;
        for (int b = 0; b < NUM_BUF; b++) begin
            if (pri[b*PRI_W +: PRI_W] != '0 && dest[b*ADDR_W +: ADDR_W] == ADDR_W'(Dest) &&
                (!found || pri[b*PRI_W +: PRI_W] < best)) begin
                found    = 1'b1;
                best     = pri[b*PRI_W +: PRI_W];
                grant    = '0;
                grant[b] = 1'b1;
            end
        end
        if (!ready) begin
            grant = '0;
        end
    end

endmodule

// File: rtl/dispatch_scheduler.sv
// Age-ranked scheduler for the router's message buffers: per-destination oldest-first grants,
// retirement with rank compaction, and in-order loading of new messages as youngest.
module dispatch_scheduler
    import router_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_BUF-1:0]        load,
    input  logic [NUM_BUF*ADDR_W-1:0] load_addr,
    input  logic [NUM_DEST-1:0]       dest_ready,
    output logic [NUM_BUF*PRI_W-1:0]  pri,
    output logic [NUM_BUF-1:0]        sel,
    output logic [NUM_BUF*ADDR_W-1:0] sel_dest,
    output logic [PRI_W-1:0]          occ,
    output logic                      err
);

    pri_t  pri_q  [NUM_BUF];
    pri_t  pri_d  [NUM_BUF];
    addr_t dest_q [NUM_BUF];
    addr_t dest_d [NUM_BUF];
    logic [PRI_W-1:0] occ_q, occ_d;
    logic             err_q, err_d;

    logic [NUM_BUF-1:0] pick [NUM_DEST];

    for (genvar d = 0; d < NUM_DEST; d++) begin : g_pick
        dest_picker #(
            .Dest(d)
        ) u_dest_picker (
            .pri  (pri),
            .dest (sel_dest),
            .ready(dest_ready[d]),
            .grant(pick[d])
        );
    end

    always_comb begin
        sel = '0;
        for (int d = 0; d < NUM_DEST; d++) begin
            sel = sel | pick[d];
        end
    end

    int unsigned surv;
    int unsigned nload;
    int unsigned drop;

    always_comb begin
        err_d = err_q;
        surv  = 0;
        nload = 0;
        drop  = 0;
        for (int b = 0; b < NUM_BUF; b++) begin
            dest_d[b] = dest_q[b];
            pri_d[b]  = '0;
        end
        // Survivors move up by the number of older buffers retiring this edge.
        for (int b = 0; b < NUM_BUF; b++) begin
            if (pri_q[b] != '0 && !sel[b]) begin
                drop = 0;
                for (int j = 0; j < NUM_BUF; j++) begin
                    if (sel[j] && pri_q[j] < pri_q[b]) begin
                        drop = drop + 1;
                    end
                end
                pri_d[b] = pri_q[b] - PRI_W'(drop);
                surv     = surv + 1;
            end
        end
        // New messages queue behind all survivors in ascending buffer order.
        for (int b = 0; b < NUM_BUF; b++) begin
            if (load[b]) begin
                if (pri_q[b] == '0 || sel[b]) begin
                    pri_d[b]  = PRI_W'(surv + nload + 1);
                    dest_d[b] = load_addr[b*ADDR_W +: ADDR_W];
                    nload     = nload + 1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        occ_d = PRI_W'(surv + nload);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BUF; b++) begin
                pri_q[b]  <= '0;
                dest_q[b] <= '0;
            end
            occ_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BUF; b++) begin
                pri_q[b]  <= pri_d[b];
                dest_q[b] <= dest_d[b];
            end
            occ_q <= occ_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        pri      = '0;
        sel_dest = '0;
        for (int b = 0; b < NUM_BUF; b++) begin
            pri[b*PRI_W +: PRI_W]       = pri_q[b];
            sel_dest[b*ADDR_W +: ADDR_W] = dest_q[b];
        end
    end

    assign occ = occ_q;
    assign err = err_q;

endmodule
